ahbl_to_apb_bridge: RTL

- AHB-Lite slave to APB master bridge with a registered response.
- Sits directly upstream of the APB splitter: its APB master port drives the splitter's APB slave port (paddr/psel/penable/pwrite/pwdata/phartid), and it consumes the splitter's merged pready/prdata/pslverr.
- Converts one pipelined AHB-Lite transfer at a time into an APB SETUP/ACCESS pair.
- Maps pslverr, and an optional access timeout, to a two-cycle AHB ERROR response.

---
 rtl/ahbl_apb_pkg.sv | 30 +++
 rtl/ahbl_to_apb_bridge_if.sv | 51 +++++
 rtl/ahbl_to_apb_bridge.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ahbl_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB bridge: HTRANS, HRESP and the bridge FSM states.
package ahbl_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] BRIDGE_IDLE   = 3'd0;
    localparam logic [2:0] BRIDGE_WDATA  = 3'd1;
    localparam logic [2:0] BRIDGE_SETUP  = 3'd2;
    localparam logic [2:0] BRIDGE_ACCESS = 3'd3;
    localparam logic [2:0] BRIDGE_DONE   = 3'd4;
    localparam logic [2:0] BRIDGE_ERR1   = 3'd5;
    localparam logic [2:0] BRIDGE_ERR2   = 3'd6;

    typedef enum logic [2:0] {
        StIdle   = BRIDGE_IDLE,
        StWdata  = BRIDGE_WDATA,
        StSetup  = BRIDGE_SETUP,
        StAccess = BRIDGE_ACCESS,
        StDone   = BRIDGE_DONE,
        StErr1   = BRIDGE_ERR1,
        StErr2   = BRIDGE_ERR2
    } bridge_state_e;

endpackage

// File: rtl/ahbl_to_apb_bridge_if.sv
// Bus bundles for the bridge: an AHB-Lite slave-side bundle and an APB bundle with hart ID sideband.
interface ahbl_if #(
    parameter int unsigned W_HADDR = 32,
    parameter int unsigned W_DATA  = 32
);
    logic               hready;
    logic               hready_resp;
    logic               hresp;
    logic [W_HADDR-1:0] haddr;
    logic               hwrite;
    logic [1:0]         htrans;
    logic [2:0]         hsize;
    logic [W_DATA-1:0]  hwdata;
    logic [W_DATA-1:0]  hrdata;
    logic [W_DATA-1:0]  hhartid;

    modport master (
        output hready, haddr, hwrite, htrans, hsize, hwdata, hhartid,
        input  hready_resp, hresp, hrdata
    );

    modport slave (
        input  hready, haddr, hwrite, htrans, hsize, hwdata, hhartid,
        output hready_resp, hresp, hrdata
    );
endinterface

interface apb_if #(
    parameter int unsigned W_PADDR = 16,
    parameter int unsigned W_DATA  = 32
);
    logic [W_PADDR-1:0] paddr;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [W_DATA-1:0]  pwdata;
    logic [W_DATA-1:0]  phartid;
    logic               pready;
    logic [W_DATA-1:0]  prdata;
    logic               pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, phartid,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, phartid,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/ahbl_to_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one transfer at a time, registered response,
// pslverr or an optional ACCESS timeout mapped to a two-cycle AHB ERROR.
module ahbl_to_apb_bridge
    import ahbl_apb_pkg::*;
#(
    parameter int unsigned W_HADDR        = 32,
    parameter int unsigned W_PADDR        = 16,
    parameter int unsigned W_DATA         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic  clk,
    input  logic  rst,
    ahbl_if.slave ahbls,
    apb_if.master apbm
);

    localparam int unsigned W_CNT = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TIMEOUT_CYCLES - 1);

    bridge_state_e      state_q;
    logic [W_PADDR-1:0] paddr_q;
    logic               psel_q;
    logic               penable_q;
    logic               pwrite_q;
    logic [W_DATA-1:0]  pwdata_q;
    logic [W_DATA-1:0]  phartid_q;
    logic               hready_resp_q;
    logic               hresp_q;
    logic [W_DATA-1:0]  hrdata_q;
    logic [W_CNT-1:0]   cnt_q;

    logic accept;
    logic timeout;
    logic unused_ahb;

    assign accept = ahbls.hready && ahbls.htrans[1];

    // Fires on the ACCESS cycle whose pready=0 would bring the count up to TIMEOUT_CYCLES.
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Word-only slave: hsize and the address bits above the APB window are not used.
    assign unused_ahb = ^{ahbls.hsize, ahbls.haddr[W_HADDR-1:W_PADDR]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            paddr_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            phartid_q     <= '0;
            hready_resp_q <= 1'b1;
            hresp_q       <= HRESP_OKAY;
            hrdata_q      <= '0;
            cnt_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr2: begin
                    hresp_q <= HRESP_OKAY;
                    if (accept) begin
                        paddr_q       <= ahbls.haddr[W_PADDR-1:0];
                        pwrite_q      <= ahbls.hwrite;
                        phartid_q     <= ahbls.hhartid;
                        hready_resp_q <= 1'b0;
                        if (ahbls.hwrite) begin
                            state_q <= StWdata;
                        end else begin
                            state_q <= StSetup;
                            psel_q  <= 1'b1;
                        end
                    end else begin
                        hready_resp_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                StWdata: begin
                    pwdata_q <= ahbls.hwdata;
                    psel_q   <= 1'b1;
                    state_q  <= StSetup;
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (apbm.pready || timeout) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (apbm.pready && !apbm.pslverr) begin
                            hready_resp_q <= 1'b1;
                            state_q       <= StDone;
                            if (!pwrite_q) begin
                                hrdata_q <= apbm.prdata;
                            end
                        end else begin
                            hresp_q <= HRESP_ERROR;
                            state_q <= StErr1;
                        end
                    end else begin
                        cnt_q <= cnt_q + W_CNT'(1);
                    end
                end
                StErr1: begin
                    hready_resp_q <= 1'b1;
                    state_q       <= StErr2;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ahbls.hready_resp = hready_resp_q;
    assign ahbls.hresp       = hresp_q;
    assign ahbls.hrdata      = hrdata_q;

    assign apbm.paddr   = paddr_q;
    assign apbm.psel    = psel_q;
    assign apbm.penable = penable_q;
    assign apbm.pwrite  = pwrite_q;
    assign apbm.pwdata  = pwdata_q;
    assign apbm.phartid = phartid_q;

endmodule
